// File: rtl/ram_ctrl.sv
// Request-side controller for a single-port RAM with a shared tristate data bus.
// Turns valid/ready requests into RAM bus cycles and sweeps memory to CLEAR_VALUE after reset.
module ram_ctrl #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    RD_LAT      = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  init_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wr_en,
  output logic [2:0]            dbg_state
);

  // Handshakes: a request transfers on a posedge where req_valid && req_ready,
  // a response on a posedge where rsp_valid && rsp_ready; a valid side holds its
  // payload stable until that edge.

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 1);
  localparam logic [1:0]            LAT_INIT  = 2'(RD_LAT - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              lat_q, lat_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    init_done_q, init_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_en_d     = wr_en_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    init_done_d = init_done_q;
    req_ready   = 1'b0;
    case (state_q)
      CLEAR: begin
        // After reset the first edge only sets up address 0; ram_addr doubles as the sweep counter.
        if (!wr_en_q) begin
          wr_en_d = 1'b1;
          addr_d  = '0;
          wdata_d = CLEAR_VALUE;
        end else if (addr_q == LAST_ADDR) begin
          wr_en_d     = 1'b0;
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      IDLE: begin
        req_ready = !clear_req;
        if (clear_req) begin
          state_d     = CLEAR;
          wr_en_d     = 1'b1;
          addr_d      = '0;
          wdata_d     = CLEAR_VALUE;
          init_done_d = 1'b0;
        end else if (req_valid) begin
          addr_d = req_addr;
          if (req_wr) begin
            wdata_d = req_wdata;
            wr_en_d = 1'b1;
            state_d = WRITE;
          end else begin
            lat_d   = LAT_INIT;
            state_d = READ;
          end
        end
      end
      WRITE: begin
        wr_en_d = 1'b0;
        state_d = IDLE;
      end
      READ: begin
        if (lat_q == 2'd0) begin
          rsp_rdata_d = ram_data;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wdata_q     <= '0;
      lat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      init_done_q <= init_done_d;
    end
  end

  // The bus is released whenever the RAM may drive it, so no turnaround cycle is needed.
  assign ram_data  = wr_en_q ? wdata_q : 'z;
  assign ram_addr  = addr_q;
  assign ram_wr_en = wr_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: RAM model on the shared bus, reference memory array,
// write/response scoreboards with expected queues.
module tb_ram_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int RD_LAT = 1;
  localparam logic [DW-1:0] CLR = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_req = 1'b0;
  logic          init_done;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  logic          ram_wr_en;
  logic [2:0]    dbg_state;

  ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT), .CLEAR_VALUE(CLR)) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wr_en(ram_wr_en),
    .dbg_state(dbg_state)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- single-port RAM model, combinational read (RD_LAT = 1) ----
  logic [DW-1:0] ram_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram_mem[i] = DW'($urandom);
  always @(posedge clk) if (ram_wr_en) ram_mem[ram_addr] <= ram_data;
  assign ram_data = ram_wr_en ? 'z : ram_mem[ram_addr];

  // ---- reference model and scoreboards ----
  logic [DW-1:0]    ref_mem [DEPTH];
  logic [DW-1:0]    exp_q[$];
  logic [AW+DW-1:0] wr_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: compares each handshaked response with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got 0x%0h expected none", rsp_rdata);
      end else begin
        chk("rsp_rdata", {16'h0, rsp_rdata}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Bus monitor: every RAM write cycle must match the next expected (addr, data).
  always @(negedge clk) begin
    if (rst_n && ram_wr_en) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected none", ram_addr, ram_data);
      end else begin
        chk("ram_write", {12'h0, ram_addr, ram_data}, {12'h0, wr_q.pop_front()});
      end
    end
  end

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      wr_q.push_back({AW'(i), CLR});
      ref_mem[i] = CLR;
    end
  endtask

  task automatic reset_and_sweep();
    int n;
    rst_n = 1'b0;
    req_valid = 1'b0; clear_req = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    exp_q.delete();
    repeat (2) step();
    push_sweep();
    rst_n = 1'b1;
    for (n = 1; n <= 40; n++) begin
      step();
      if (init_done) break;
      if (req_ready !== 1'b0) chk("req_ready_in_clear", req_ready, 0);
    end
    chk("init_done_edge", n, DEPTH + 1);
    chk("sweep_left", wr_q.size(), 0);
  endtask

  task automatic wait_accept(output int n);
    logic acc;
    for (n = 1; n <= 100; n++) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      step();
      if (acc) return;
    end
    chk("accept_timeout", 1, 0);
  endtask

  task automatic write_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
    wait_accept(n);
    wr_q.push_back({a, d});
    ref_mem[a] = d;
    req_valid = 1'b0;
    step();
  endtask

  task automatic read_req(input logic [AW-1:0] a, input int hold);
    int n;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a; rsp_ready = 1'b0;
    wait_accept(n);
    exp_q.push_back(ref_mem[a]);
    req_valid = 1'b0;
    if (ram_addr !== a || ram_wr_en !== 1'b0) chk("read_addr_phase", {ram_wr_en, 3'b0, ram_addr}, {8'h0, 4'h0, a});
    for (n = 1; n <= 20; n++) begin
      step();
      if (rsp_valid) break;
    end
    chk("read_latency", n, RD_LAT);
    for (int h = 0; h < hold; h++) begin
      chk("rsp_hold_valid", rsp_valid, 1);
      chk("rsp_hold_data", rsp_rdata, ref_mem[a]);
      chk("rsp_hold_req_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  // ---- main sequence ----
  initial begin
    int n;
    logic acc, id;
    reset_and_sweep();

    // Basic write/read, then a read held off for 5 cycles.
    write_req(4'd5, 16'hA5A5);
    read_req(4'd5, 0);
    read_req(4'd3, 5);

    // Address boundaries.
    write_req(4'd15, 16'hFFFF);
    write_req(4'd0, 16'h1234);
    read_req(4'd15, 1);
    read_req(4'd0, 0);

    // clear_req wins over a simultaneous write; the write is held until after the sweep.
    clear_req = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd15; req_wdata = 16'hC3C3;
    @(negedge clk);
    chk("clear_prio_req_ready", req_ready, 0);
    step();
    push_sweep();
    clear_req = 1'b0;
    chk("clear_init_drop", init_done, 0);
    id = 1'b0;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      id = init_done;
      step();
      if (acc) break;
    end
    chk("held_write_cycle", n, DEPTH + 1);
    chk("held_write_init_done", id, 1);
    wr_q.push_back({4'd15, 16'hC3C3});
    ref_mem[15] = 16'hC3C3;
    req_valid = 1'b0;
    step();
    read_req(4'd0, 0);
    read_req(4'd15, 2);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) write_req(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      else read_req(AW'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 3)));
    end

    // Reset while a read is in flight: the response must never appear.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd7; rsp_ready = 1'b1;
    wait_accept(n);
    req_valid = 1'b0;
    reset_and_sweep();
    rsp_ready = 1'b1;
    repeat (8) step();
    chk("no_stale_rsp", rsp_valid, 0);
    rsp_ready = 1'b0;
    read_req(4'd7, 0);

    repeat (3) step();
    chk("exp_q_empty", exp_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
